// File: rtl/bcd_pkg.sv
// Shared types and constants for the BCD to excess-3 word sequencer.
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [3:0] EXC3_OFFSET = 4'd3;
  localparam logic [3:0] BCD_MAX     = 4'd9;

  function automatic logic is_bcd(input logic [3:0] d);
    return d <= BCD_MAX;
  endfunction

endpackage

// File: rtl/BCD.sv
// 4-bit BCD to excess-3 converter (d+3), purely combinational.
module BCD
  import bcd_pkg::*;
(
  input  logic in_A,
  input  logic in_B,
  input  logic in_C,
  input  logic in_D,
  output logic out_W,
  output logic out_X,
  output logic out_Y,
  output logic out_Z
);

  assign {out_W, out_X, out_Y, out_Z} = {in_A, in_B, in_C, in_D} + EXC3_OFFSET;

endmodule

// File: rtl/bcd_seq_ctrl.sv
// Converts an NDIG-digit packed BCD word to excess-3, one digit per cycle,
// time-sharing a single BCD converter; flags digits above 9.
module bcd_seq_ctrl
  import bcd_pkg::*;
#(
  parameter int unsigned NDIG = 4
) (
  input  logic              in_clk,
  input  logic              in_rst,
  input  logic              in_valid,
  output logic              out_ready,
  input  logic [4*NDIG-1:0] in_data,
  output logic              out_valid,
  input  logic              in_ready,
  output logic [4*NDIG-1:0] out_data,
  output logic              out_err,
  output logic              out_busy
);

  localparam int unsigned W  = 4 * NDIG;
  localparam int unsigned CW = (NDIG > 1) ? $clog2(NDIG) : 1;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [W-1:0]    opnd;
  logic [W-1:0]    res;
  logic            err;
  logic [3:0]      dig_c;
  logic [3:0]      exc_c;

  // Digit selected for the shared converter
  always_comb dig_c = opnd[4*int'(cnt) +: 4];

  BCD u_bcd (
    .in_A  (dig_c[3]),
    .in_B  (dig_c[2]),
    .in_C  (dig_c[1]),
    .in_D  (dig_c[0]),
    .out_W (exc_c[3]),
    .out_X (exc_c[2]),
    .out_Y (exc_c[1]),
    .out_Z (exc_c[0])
  );

  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      state <= IDLE;
      cnt   <= '0;
      opnd  <= '0;
      res   <= '0;
      err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            opnd  <= in_data;
            res   <= '0;
            err   <= 1'b0;
            cnt   <= '0;
            state <= CONV;
          end
        end
        CONV: begin
          // Illegal digits read back as zero and set the sticky error
          if (is_bcd(dig_c)) begin
            res[4*int'(cnt) +: 4] <= exc_c;
          end else begin
            res[4*int'(cnt) +: 4] <= 4'h0;
            err                   <= 1'b1;
          end
          if (cnt == CW'(NDIG - 1)) state <= DONE;
          else                      cnt   <= cnt + CW'(1);
        end
        DONE: begin
          if (in_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign out_ready = (state == IDLE);
  assign out_valid = (state == DONE);
  assign out_busy  = (state != IDLE);
  assign out_data  = res;
  assign out_err   = err;

endmodule

// File: tb/tb_bcd_seq_ctrl.sv
// Self-checking bench for bcd_seq_ctrl: directed vector table, corner
// sequences, and random words against a digit-arithmetic reference model.
module tb_bcd_seq_ctrl;

  localparam int unsigned NDIG = 4;
  localparam int unsigned W    = 4 * NDIG;

  logic         in_clk;
  logic         in_rst;
  logic         in_valid;
  logic         out_ready;
  logic [W-1:0] in_data;
  logic         out_valid;
  logic         in_ready;
  logic [W-1:0] out_data;
  logic         out_err;
  logic         out_busy;

  int nvec = 0;
  int nerr = 0;

  bcd_seq_ctrl #(.NDIG(NDIG)) dut (
    .in_clk    (in_clk),
    .in_rst    (in_rst),
    .in_valid  (in_valid),
    .out_ready (out_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_err   (out_err),
    .out_busy  (out_busy)
  );

  initial in_clk = 1'b0;
  always #5 in_clk = ~in_clk;

  typedef struct {
    logic [W-1:0] din;
    logic [W-1:0] exp;
    logic         exp_err;
    int           bp;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: each digit independently becomes d+3, or 0 with error if d>9
  function automatic logic [W:0] model(input logic [W-1:0] w);
    logic [W-1:0] r;
    logic         e;
    r = '0;
    e = 1'b0;
    for (int i = 0; i < int'(NDIG); i++) begin
      int d;
      d = int'((w >> (4 * i)) & 16'hF);
      if (d > 9) e = 1'b1;
      else       r = r | (W'(d + 3) << (4 * i));
    end
    return {e, r};
  endfunction

  task automatic tick();
    @(posedge in_clk);
    #1;
  endtask

  // Send one word, check latency/result, hold in_ready low for bp DONE cycles
  task automatic run_word(input logic [W-1:0] din, input logic [W-1:0] exp,
                          input logic exp_err, input int bp);
    int k;
    k = 0;
    while (!out_ready && k < 20) begin tick(); k++; end
    chk("ready_before_accept", 32'(out_ready), 32'd1);
    in_valid = 1'b1;
    in_data  = din;
    in_ready = (bp == 0);
    tick();
    in_valid = 1'b0;
    in_data  = W'($urandom);
    chk("busy_after_accept", 32'(out_busy), 32'd1);
    chk("data_cleared_on_accept", 32'(out_data), 32'd0);
    k = 0;
    while (!out_valid && k < 20) begin tick(); k++; end
    chk("latency", 32'(k), 32'(NDIG));
    chk("out_data", 32'(out_data), 32'(exp));
    chk("out_err", 32'(out_err), 32'(exp_err));
    chk("ready_low_in_done", 32'(out_ready), 32'd0);
    for (int i = 0; i < bp; i++) begin
      tick();
      chk("bp_valid_held", 32'(out_valid), 32'd1);
      chk("bp_data_stable", 32'(out_data), 32'(exp));
      chk("bp_ready_low", 32'(out_ready), 32'd0);
    end
    in_ready = 1'b1;
    tick();
    chk("idle_after_handshake", 32'(out_ready), 32'd1);
    chk("valid_dropped", 32'(out_valid), 32'd0);
    chk("data_kept_after_hs", 32'(out_data), 32'(exp));
  endtask

  vec_t vecs[$];

  initial begin
    logic [W:0] m;
    logic [W-1:0] w;
    int k;

    vecs.push_back('{16'h1234, 16'h4567, 1'b0, 0});
    vecs.push_back('{16'h0999, 16'h3CCC, 1'b0, 0});
    vecs.push_back('{16'h9000, 16'hC333, 1'b0, 0});
    vecs.push_back('{16'h12A4, 16'h4507, 1'b1, 0});
    vecs.push_back('{16'h0000, 16'h3333, 1'b0, 0});
    vecs.push_back('{16'h9876, 16'hCBA9, 1'b0, 3});
    vecs.push_back('{16'hFFFF, 16'h0000, 1'b1, 1});

    in_rst   = 1'b1;
    in_valid = 1'b0;
    in_ready = 1'b1;
    in_data  = '0;
    #12;
    chk("rst_ready", 32'(out_ready), 32'd1);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(out_busy), 32'd0);
    chk("rst_data", 32'(out_data), 32'd0);
    chk("rst_err", 32'(out_err), 32'd0);
    @(negedge in_clk);
    in_rst = 1'b0;
    tick();

    foreach (vecs[i]) run_word(vecs[i].din, vecs[i].exp, vecs[i].exp_err, vecs[i].bp);

    // Asynchronous reset in mid-conversion
    in_valid = 1'b1;
    in_data  = 16'h1357;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    #2;
    in_rst = 1'b1;
    #1;
    chk("async_rst_busy", 32'(out_busy), 32'd0);
    chk("async_rst_ready", 32'(out_ready), 32'd1);
    chk("async_rst_data", 32'(out_data), 32'd0);
    chk("async_rst_err", 32'(out_err), 32'd0);
    chk("async_rst_valid", 32'(out_valid), 32'd0);
    @(negedge in_clk);
    in_rst = 1'b0;
    tick();
    run_word(16'h5678, 16'h89AB, 1'b0, 0);

    // Back-to-back with in_valid held high
    in_ready = 1'b1;
    in_valid = 1'b1;
    in_data  = 16'h1111;
    tick();
    in_data  = 16'h2222;
    chk("b2b_first_accept", 32'(out_busy), 32'd1);
    k = 0;
    while (!out_valid && k < 20) begin tick(); k++; end
    chk("b2b_first_latency", 32'(k), 32'(NDIG));
    chk("b2b_first_data", 32'(out_data), 32'h4444);
    tick();
    chk("b2b_idle_gap", 32'(out_ready), 32'd1);
    chk("b2b_idle_data", 32'(out_data), 32'h4444);
    tick();
    in_valid = 1'b0;
    chk("b2b_second_accept", 32'(out_busy), 32'd1);
    chk("b2b_second_cleared", 32'(out_data), 32'd0);
    k = 0;
    while (!out_valid && k < 20) begin tick(); k++; end
    chk("b2b_second_latency", 32'(k), 32'(NDIG));
    chk("b2b_second_data", 32'(out_data), 32'h5555);
    tick();
    tick();
    tick();
    chk("b2b_no_extra_word", 32'(out_busy), 32'd0);
    chk("b2b_data_held", 32'(out_data), 32'h5555);

    // Random words, biased to include illegal digits
    for (int n = 0; n < 40; n++) begin
      w = '0;
      for (int i = 0; i < int'(NDIG); i++) begin
        int d;
        d = ($urandom_range(0, 3) == 0) ? int'($urandom_range(10, 15)) : int'($urandom_range(0, 9));
        w = w | (W'(d) << (4 * i));
      end
      m = model(w);
      run_word(w, m[W-1:0], m[W], int'($urandom_range(0, 2)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
